// File: rtl/riscv_mul_unit.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One operation in flight; XLEN compute cycles, or an immediate result when an operand is zero.
module riscv_mul_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_op_a,
    input  logic [XLEN-1:0]  in_op_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    // state | meaning
    // IDLE  | waiting for an operation from the decoder
    // CALC  | one multiplier bit per edge, LSB first
    // DONE  | result held for writeback until out_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [1:0] FN_MUL    = 2'b00;
    localparam logic [1:0] FN_MULH   = 2'b01;
    localparam logic [1:0] FN_MULHSU = 2'b10;

    state_t              state, state_nx;
    logic [1:0]          fn_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mplier_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                op_zero;
    logic                last;
    logic [2*XLEN-1:0]   acc_sum;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     prod_sel;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

    // Magnitude of 0x80000000 is 2^31, which still fits unsigned XLEN bits.
    assign a_neg   = in_op_a[XLEN-1] && ((in_funct3[1:0] == FN_MULH) || (in_funct3[1:0] == FN_MULHSU));
    assign b_neg   = in_op_b[XLEN-1] && (in_funct3[1:0] == FN_MULH);
    assign mag_a   = a_neg ? (~in_op_a + XLEN'(1)) : in_op_a;
    assign mag_b   = b_neg ? (~in_op_b + XLEN'(1)) : in_op_b;
    assign op_zero = (in_op_a == '0) || (in_op_b == '0);

    assign last     = (cnt_q == CNT_W'(XLEN - 1));
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_fix = neg_q ? (~acc_sum + (2*XLEN)'(1)) : acc_sum;
    assign prod_sel = (fn_q == FN_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = op_zero ? DONE : CALC;
            CALC: if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fn_q       <= '0;
            neg_q      <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                fn_q     <= in_funct3[1:0];
                neg_q    <= a_neg ^ b_neg;
                mcand_q  <= {{XLEN{1'b0}}, mag_a};
                mplier_q <= mag_b;
                acc_q    <= '0;
                cnt_q    <= '0;
                out_tag  <= in_tag;
                if (op_zero) out_result <= '0;
            end else if (state == CALC && !flush) begin
                acc_q    <= acc_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last) out_result <= prod_sel;
            end
        end
    end

endmodule

// File: tb/tb_riscv_mul_unit.sv
// Self-checking bench for riscv_mul_unit: directed plan cases plus random operations
// compared against a 64-bit arithmetic reference model.
module tb_riscv_mul_unit;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_op_a;
    logic [XLEN-1:0]  in_op_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    riscv_mul_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Reference: extend each operand per its signedness, take the 64-bit product, pick the half.
    function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {32'b0, a};
        eb = {32'b0, b};
        if (f[1:0] == 2'b01 || f[1:0] == 2'b10) ea = {{32{a[31]}}, a};
        if (f[1:0] == 2'b01) eb = {{32{b[31]}}, b};
        p = ea * eb;
        return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op and return after the acceptance edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_funct3 = f;
        in_op_a   = a;
        in_op_b   = b;
        in_tag    = t;
        step();
        in_valid  = 1'b0;
        in_op_a   = $urandom;
        in_op_b   = $urandom;
        in_tag    = 5'($urandom);
    endtask

    // Count edges after acceptance until out_valid; also checks in_ready is low mid-compute.
    task automatic wait_done(input int exp_lat);
        int n = 0;
        while (!out_valid && n < 40) begin
            if (n == 5) check("in_ready_low_calc", 64'(in_ready), 64'd0);
            step();
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp);
        issue(f, a, b, t);
        wait_done((a == 0 || b == 0) ? 0 : 32);
        check({name, "_result"}, 64'(out_result), 64'(exp));
        check({name, "_tag"}, 64'(out_tag), 64'(t));
        check({name, "_in_ready_done"}, 64'(in_ready), 64'd0);
        handshake();
    endtask

    initial begin
        logic [31:0] hold_r;
        logic [4:0]  hold_t;
        logic        seen;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  t;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_funct3 = '0;
        in_op_a = '0; in_op_b = '0; in_tag = '0; out_ready = 1'b0;
        step(); step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        run_op("mul_neg7", 3'b000, 32'd7, 32'hFFFFFFF9, 5'd3, 32'hFFFFFFCF);
        run_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 5'd9, 32'h40000000);
        run_op("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'hFFFFFFFF);
        run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFE);
        run_op("mulh_mix", 3'b001, 32'h80000000, 32'd1, 5'd4, 32'hFFFFFFFF);

        // Early-out with backpressure.
        issue(3'b011, 32'd0, 32'h1234, 5'd12);
        wait_done(0);
        check("eo_result", 64'(out_result), 64'd0);
        check("eo_tag", 64'(out_tag), 64'd12);
        hold_r = out_result;
        hold_t = out_tag;
        seen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!out_valid || out_result !== hold_r || out_tag !== hold_t) seen = 1'b0;
        end
        check("eo_backpressure_stable", 64'(seen), 64'd1);
        handshake();

        // Flush at CALC count 10.
        issue(3'b000, 32'd3, 32'd5, 5'd6);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_delivery", 64'(seen), 64'd0);
        run_op("mul_3x5", 3'b000, 32'd3, 32'd5, 5'd7, 32'd15);

        // Reset while holding a result in DONE.
        issue(3'b000, 32'd3, 32'd5, 5'd21);
        wait_done(32);
        check("pre_rst_result", 64'(out_result), 64'd15);
        rst = 1'b1;
        step();
        check("rst_done_out_valid", 64'(out_valid), 64'd0);
        check("rst_done_out_result", 64'(out_result), 64'd0);
        check("rst_done_out_tag", 64'(out_tag), 64'd0);
        check("rst_done_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;

        // Flush and in_valid in the same idle cycle: an accepted zero op would show out_valid immediately.
        in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'b000; in_op_a = 32'd0; in_op_b = 32'd9; in_tag = 5'd2;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("collide_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("collide_not_accepted", 64'(seen), 64'd0);

        // Random operations, including zero and most-negative corners and random out_ready delay.
        for (int k = 0; k < 40; k++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: b = 32'h80000000;
                2: a = 32'h80000000;
                default: ;
            endcase
            t = 5'($urandom);
            issue(f, a, b, t);
            wait_done((a == 0 || b == 0) ? 0 : 32);
            for (int d = $urandom_range(0, 3); d > 0; d--) step();
            check("rand_result", 64'(out_result), 64'(ref_mul(f, a, b)));
            check("rand_tag", 64'(out_tag), 64'(t));
            handshake();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
